wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Writeback arbiter that sits directly upstream of the register file and owns its single write port. It merges two result sources into one registered write per cycle:
- the in-order pipeline writeback, which has no backpressure;
- a long-latency unit (load/mul/div), which uses a valid/ready handshake and a small FIFO.

It also keeps a pending-register scoreboard so the hazard unit can stall reads of registers whose long-latency results are still outstanding.

## Interface

Parameters:
- FIFO_DEPTH, 2, depth of the long-latency result FIFO; power of two, ≥2
- STARVE_LIMIT, 4, consecutive cycles the FIFO head may lose arbitration before stall_req asserts; range 1–15

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- p_valid  in  1  pipeline writeback valid; always accepted
- p_rd  in  5  pipeline destination register
- p_data  in  32  pipeline result
- l_valid  in  1  long-latency result valid
- l_ready  out  1  FIFO can accept; equals (count != FIFO_DEPTH)
- l_rd  in  5  long-latency destination register
- l_data  in  32  long-latency result
- iss_valid  in  1  long-latency op issued this cycle
- iss_rd  in  5  destination register of the issued op
- stall_req  out  1  upstream must hold p_valid=0 while high
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  5  register-file write address (registered)
- rf_wdata  out  32  register-file write data (registered)
- pend  out  32  scoreboard; bit i=1 means a long-latency result for xi is outstanding; bit 0 is constant 0

## Operation

Long-latency FIFO:
- Push on the clock edge where l_valid && l_ready.
- Head pops when it is selected by the arbiter.
- l_ready depends only on the registered count, never on same-cycle pop. A full FIFO therefore rejects a push even in a cycle that pops.
- Pointers wrap modulo FIFO_DEPTH. The count is log2(FIFO_DEPTH)+1 bits wide.

Arbitration, evaluated each cycle:
- If stall_req=1 and the FIFO is non-empty, select the FIFO head. If p_valid is high here it is a protocol violation: p_valid is ignored and the bench flags it.
- Otherwise, if p_valid=1, select the pipeline.
- Otherwise, if the FIFO is non-empty, select the FIFO head.
- Otherwise, select nothing.

Write port register, updated on every edge:
- rf_we ← selection valid && selected rd != 0
- rf_waddr and rf_wdata ← selected rd and data when a selection exists; otherwise they hold their previous values.
- An rd=0 entry is still consumed, with rf_we=0.

Starvation counter:
- Width 4 bits.
- Cleared when the FIFO is empty or the head pops.
- Otherwise it increments, saturating at STARVE_LIMIT.
- stall_req = (counter == STARVE_LIMIT).

Scoreboard:
- Set: iss_valid && iss_rd != 0 sets pend[iss_rd].
- Clear: a FIFO head popped with rd != 0 clears pend[rd] on the same edge that rf_we is registered.
- Set and clear of the same register on the same edge: set wins, because a new issue supersedes the old result.
- Pipeline writes never modify pend.

## Timing

- Reset (asynchronous, immediate) gives:
  - rf_we=0, rf_waddr=0, rf_wdata=0
  - pend=0, FIFO empty, counter=0
  - stall_req=0, l_ready=1
- Pipeline latency: p_valid sampled at edge N appears on rf_we/rf_waddr/rf_wdata after edge N, i.e. valid during cycle N+1. The register file writes at edge N+1.
- FIFO latency: an entry pushed at edge N is eligible for selection in the cycle after N. With no contention it is on the write port after edge N+1.
- Throughput: one register-file write per cycle, maximum.
- Full FIFO: l_ready=0 for the whole cycle. The producer must hold l_valid, l_rd and l_data stable until accepted.
- Reset asserted mid-operation discards FIFO contents and pend, and drops any in-flight write. No partial write occurs after reset release.
- stall_req changes only on clock edges. It deasserts after the edge on which the starved head pops.

## Test plan

- Reset then idle: rf_we=0, pend=0, l_ready=1, stall_req=0. Pipeline write x5=0xDEADBEEF at edge 1 → rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF during cycle 2.
- Issue x7, then push l_rd=7, l_data=0x1234 with p_valid=0: pend[7]=1 after the issue edge; rf_we for x7 appears one cycle after the push; pend[7]=0 on that same edge.
- FIFO fill with FIFO_DEPTH=2: keep p_valid=1 every cycle with rd=x1 and push 3 results back-to-back → l_ready=0 after the second push; the third is held until a pop; no entry is lost or duplicated.
- Starvation with STARVE_LIMIT=4: FIFO non-empty and p_valid=1 continuously → stall_req rises after 4 losing cycles. With p_valid then 0, the head writes next, and stall_req falls the following cycle.
- Writes to x0: pipeline rd=0 and FIFO rd=0 → rf_we stays 0, the FIFO entry is consumed, and pend[0] stays 0. iss_rd=0 → no pend change.
- Same-edge set/clear on x9, and async reset mid-burst: pend[9]=1 after the shared edge. Asserting rst_n=0 while the FIFO holds 2 entries → all outputs return to reset values immediately, and no write follows release.

Source files
------------

// File: rtl/wb_arbiter.sv
// wb_arbiter: owns the register-file write port and merges two result streams.
//   - in-order pipeline writeback (p_*): no backpressure, always accepted
//   - long-latency results (l_*): valid/ready into a small FIFO
// Also tracks outstanding long-latency destinations in a pending scoreboard.
//
// Ports
//   clk, rst_n                   clock, async active-low reset
//   p_valid/p_rd/p_data          pipeline writeback
//   l_valid/l_ready/l_rd/l_data  long-latency result handshake
//   iss_valid/iss_rd             long-latency issue (sets pend)
//   stall_req                    upstream must hold p_valid=0 while high
//   rf_we/rf_waddr/rf_wdata      registered register-file write port
//   pend                         scoreboard, bit 0 always 0
module wb_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p_valid,
  input  logic [4:0]  p_rd,
  input  logic [31:0] p_data,
  input  logic        l_valid,
  output logic        l_ready,
  input  logic [4:0]  l_rd,
  input  logic [31:0] l_data,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  output logic        stall_req,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] pend
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  localparam logic [3:0]    SLIM = 4'(STARVE_LIMIT);

  logic [4:0]    frd_q   [FIFO_DEPTH];
  logic [31:0]   fdata_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    starve_q, starve_d;
  logic [31:0]   pend_q, pend_d;
  logic          rf_we_q, rf_we_d;
  logic [4:0]    rf_waddr_q, rf_waddr_d;
  logic [31:0]   rf_wdata_q, rf_wdata_d;

  logic          fifo_ne, push, sel_fifo, sel_pipe;
  logic [4:0]    sel_rd;
  logic [31:0]   sel_data, set_vec, clr_vec;

  // l_ready looks only at the registered count: a full FIFO refuses a push
  // even in a cycle that pops, which keeps ready off the arbitration path.
  assign l_ready   = (cnt_q != FULL);
  assign stall_req = (starve_q == SLIM);
  assign fifo_ne   = (cnt_q != '0);
  assign push      = l_valid && l_ready;

  // Starved head wins outright; otherwise the pipeline has priority.
  assign sel_fifo  = fifo_ne && (stall_req || !p_valid);
  assign sel_pipe  = p_valid && !sel_fifo;
  assign sel_rd    = sel_fifo ? frd_q[rd_ptr_q]   : p_rd;
  assign sel_data  = sel_fifo ? fdata_q[rd_ptr_q] : p_data;

  always_comb begin
    cnt_d      = cnt_q + CW'(push) - CW'(sel_fifo);
    rf_we_d    = (sel_fifo || sel_pipe) && (sel_rd != 5'd0);
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (sel_fifo || sel_pipe) begin
      rf_waddr_d = sel_rd;
      rf_wdata_d = sel_data;
    end
    starve_d = starve_q;
    if (!fifo_ne || sel_fifo) starve_d = 4'd0;
    else if (starve_q != SLIM) starve_d = starve_q + 4'd1;
    set_vec = '0;
    clr_vec = '0;
    if (iss_valid && iss_rd != 5'd0) set_vec = 32'd1 << iss_rd;
    if (sel_fifo && sel_rd != 5'd0)  clr_vec = 32'd1 << sel_rd;
    // A new issue supersedes a result retiring on the same edge.
    pend_d = ((pend_q & ~clr_vec) | set_vec) & ~32'd1;
  end

  // FIFO storage needs no reset; validity is carried by cnt_q.
  always_ff @(posedge clk) begin
    if (push) begin
      frd_q[wr_ptr_q]   <= l_rd;
      fdata_q[wr_ptr_q] <= l_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      starve_q   <= '0;
      pend_q     <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      if (push)     wr_ptr_q <= wr_ptr_q + AW'(1);
      if (sel_fifo) rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
      pend_q     <= pend_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign pend     = pend_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus a randomized
// phase, all compared against a queue-based reference model.
module tb_wb_arbiter;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk, rst_n;
  logic        p_valid, l_valid, iss_valid;
  logic [4:0]  p_rd, l_rd, iss_rd;
  logic [31:0] p_data, l_data;
  logic        l_ready, stall_req, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, pend;

  wb_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .p_valid(p_valid), .p_rd(p_rd), .p_data(p_data),
    .l_valid(l_valid), .l_ready(l_ready), .l_rd(l_rd), .l_data(l_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .stall_req(stall_req),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pend(pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [4:0] rd; logic [31:0] d; } ent_t;

  // reference model state
  ent_t        mq[$];
  int          m_starve;
  logic [31:0] m_pend;
  logic        m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;

  int n_chk, n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_starve = 0;
    m_pend   = '0;
    m_we     = 1'b0;
    m_waddr  = '0;
    m_wdata  = '0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".rf_we"},    {31'd0, rf_we},      {31'd0, m_we});
    check({tag, ".rf_waddr"}, {27'd0, rf_waddr},   {27'd0, m_waddr});
    check({tag, ".rf_wdata"}, rf_wdata,            m_wdata);
    check({tag, ".pend"},     pend,                m_pend);
    check({tag, ".l_ready"},  {31'd0, l_ready},    {31'd0, mq.size() != DEPTH});
    check({tag, ".stall"},    {31'd0, stall_req},  {31'd0, m_starve == LIMIT});
  endtask

  function automatic bit m_stall();
    return m_starve == LIMIT;
  endfunction

  // Drive one cycle of inputs (called just after a falling edge), advance the
  // model by the arbitration rules, then compare after the next falling edge.
  task automatic step(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                      input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                      input logic iv, input logic [4:0] ird, output bit acc);
    bit   stall, ready, ne;
    int   src;  // 0 none, 1 fifo head, 2 pipeline
    ent_t e;
    p_valid = pv;  p_rd = prd;  p_data = pd;
    l_valid = lv;  l_rd = lrd;  l_data = ld;
    iss_valid = iv; iss_rd = ird;
    stall = m_stall();
    ready = mq.size() != DEPTH;
    ne    = mq.size() > 0;
    if (stall && ne) src = 1;
    else if (pv)     src = 2;
    else if (ne)     src = 1;
    else             src = 0;
    m_we = 1'b0;
    if (src == 1) begin
      e = mq.pop_front();
      m_we = e.rd != 0; m_waddr = e.rd; m_wdata = e.d;
      if (e.rd != 0) m_pend[e.rd] = 1'b0;
    end else if (src == 2) begin
      m_we = prd != 0; m_waddr = prd; m_wdata = pd;
    end
    if (iv && ird != 0) m_pend[ird] = 1'b1;
    acc = lv && ready;
    if (acc) begin e.rd = lrd; e.d = ld; mq.push_back(e); end
    if (!ne || src == 1) m_starve = 0;
    else if (m_starve < LIMIT) m_starve++;
    @(posedge clk);
    @(negedge clk);
    check_all("step");
  endtask

  task automatic idle();
    bit a;
    step(0, 0, 0, 0, 0, 0, 0, 0, a);
  endtask

  initial begin
    bit acc;
    int seen [3];
    int k;
    bit hv; logic [4:0] hrd; logic [31:0] hd;
    logic pv;
    n_chk = 0; n_err = 0;
    rst_n = 1'b0;
    p_valid = 0; p_rd = 0; p_data = 0;
    l_valid = 0; l_rd = 0; l_data = 0;
    iss_valid = 0; iss_rd = 0;
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle();

    // pipeline write x5
    step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, acc);
    check("pipe.we",    {31'd0, rf_we}, 32'd1);
    check("pipe.waddr", {27'd0, rf_waddr}, 32'd5);
    check("pipe.wdata", rf_wdata, 32'hDEADBEEF);

    // issue x7, then long-latency result for x7
    step(0, 0, 0, 0, 0, 0, 1, 7, acc);
    check("iss7.pend", {31'd0, pend[7]}, 32'd1);
    step(0, 0, 0, 1, 7, 32'h1234, 0, 0, acc);
    check("push7.we", {31'd0, rf_we}, 32'd0);
    idle();
    check("pop7.we",    {31'd0, rf_we}, 32'd1);
    check("pop7.waddr", {27'd0, rf_waddr}, 32'd7);
    check("pop7.wdata", rf_wdata, 32'h1234);
    check("pop7.pend",  {31'd0, pend[7]}, 32'd0);

    // fill FIFO under continuous pipeline traffic; hold third until accepted
    seen = '{0, 0, 0};
    k = 0;
    for (int c = 0; c < 16; c++) begin
      pv = !m_stall();
      step(pv, 1, 32'h100 + c, k < 3, 5'(10 + k), 32'hA0 + k, 0, 0, acc);
      if (c == 1) check("fill.l_ready", {31'd0, l_ready}, 32'd0);
      if (acc) k++;
      for (int j = 0; j < 3; j++)
        if (rf_we && rf_waddr == 5'(10 + j)) seen[j]++;
    end
    for (int c = 0; c < 4; c++) begin
      idle();
      for (int j = 0; j < 3; j++)
        if (rf_we && rf_waddr == 5'(10 + j)) seen[j]++;
    end
    check("fill.accepted", k, 3);
    for (int j = 0; j < 3; j++) check($sformatf("fill.once%0d", j), seen[j], 1);

    // starvation: head loses LIMIT cycles, then wins once p_valid drops
    step(1, 2, 32'h2, 1, 20, 32'h5A5A, 0, 0, acc);
    for (int c = 0; c < LIMIT; c++) begin
      check("starve.pre", {31'd0, stall_req}, 32'd0);
      step(1, 2, 32'h2, 0, 0, 0, 0, 0, acc);
    end
    check("starve.stall", {31'd0, stall_req}, 32'd1);
    idle();
    check("starve.waddr", {27'd0, rf_waddr}, 32'd20);
    check("starve.fall",  {31'd0, stall_req}, 32'd0);

    // x0 writes
    step(1, 0, 32'h77, 0, 0, 0, 0, 0, acc);
    check("x0.pipe.we", {31'd0, rf_we}, 32'd0);
    step(0, 0, 0, 1, 0, 32'h88, 0, 0, acc);
    idle();
    check("x0.fifo.we",   {31'd0, rf_we}, 32'd0);
    check("x0.fifo.empty", {31'd0, l_ready}, 32'd1);
    step(0, 0, 0, 0, 0, 0, 1, 0, acc);
    check("x0.pend", pend, 32'd0);

    // same-edge set/clear on x9
    step(0, 0, 0, 0, 0, 0, 1, 9, acc);
    step(0, 0, 0, 1, 9, 32'h99, 0, 0, acc);
    step(0, 0, 0, 0, 0, 0, 1, 9, acc);
    check("x9.we",   {31'd0, rf_we}, 32'd1);
    check("x9.pend", {31'd0, pend[9]}, 32'd1);

    // async reset with two entries queued
    step(1, 1, 32'h11, 1, 3, 32'h33, 1, 3, acc);
    step(1, 1, 32'h12, 1, 4, 32'h44, 0, 0, acc);
    check("rst.full", {31'd0, l_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    p_valid = 0; l_valid = 0; iss_valid = 0;
    #1;
    model_reset();
    check_all("rst.async");
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      idle();
      check("rst.nowrite", {31'd0, rf_we}, 32'd0);
    end

    // randomized traffic honouring stall_req and the hold-until-accepted rule
    hv = 0; hrd = 0; hd = 0;
    for (int c = 0; c < 600; c++) begin
      if (!hv && ($urandom_range(0, 99) < 50)) begin
        hv = 1; hrd = 5'($urandom_range(0, 31)); hd = $urandom;
      end
      pv = !m_stall() && ($urandom_range(0, 99) < 60);
      step(pv, 5'($urandom_range(0, 31)), $urandom, hv, hrd, hd,
           $urandom_range(0, 99) < 30, 5'($urandom_range(0, 31)), acc);
      if (acc) hv = 0;
      if (c == 300) begin
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        hv = 0;
        check_all("rand.rst");
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
